// File: rtl/motor_cfg_master.sv
// -----------------------------------------------------------------------------
// motor_cfg_master
//
// Avalon-MM write master that programs NUM_CH PWM motor-controller channels.
// For every channel it writes HIGH_DUR (reg 1), TOTAL_DUR (reg 0) and
// CONTROL (reg 2), in that order, channels 0..NUM_CH-1. One sweep runs
// automatically after reset; further sweeps run on update_req using a
// snapshot of the live inputs taken when the sweep starts. Requests that
// arrive while a sweep is running coalesce into a single follow-up sweep.
// A write stalled on waitrequest for TIMEOUT cycles aborts the sweep and
// sets the sticky err flag, which is cleared when the next sweep starts.
//
// Optional feature (macro SKIP_UNCHANGED_EN): shadow copies of the last
// accepted value per (channel, register) let a sweep skip writes whose
// value has not changed.
//
// Parameters:
//   NUM_CH   number of motor channels (1..8)
//   CH_W     channel-select address bits, 2**CH_W >= NUM_CH, CH_W >= 1
//   TIMEOUT  max stalled cycles of one write before abort
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   period            shared PWM total duration (clk ticks)
//   duty              per-channel high duration, channel k at [32k+31:32k]
//   forward/go/fast_decay  per-channel direction / enable / decay mode
//   update_req        single-cycle sweep request
//   s_cs, s_write     chip select and write strobe (asserted together)
//   s_read            tied low
//   s_address         {channel, 4-bit register index}
//   s_writedata       write data
//   waitrequest       slave stall
//   busy              sweep in progress
//   done              one-cycle pulse at sweep end
//   err               sticky timeout flag
// -----------------------------------------------------------------------------
module motor_cfg_master #(
  parameter int NUM_CH  = 2,
  parameter int CH_W    = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           period,
  input  logic [32*NUM_CH-1:0]  duty,
  input  logic [NUM_CH-1:0]     forward,
  input  logic [NUM_CH-1:0]     go,
  input  logic [NUM_CH-1:0]     fast_decay,
  input  logic                  update_req,
  output logic                  s_cs,
  output logic [CH_W+3:0]       s_address,
  output logic                  s_write,
  output logic                  s_read,
  output logic [31:0]           s_writedata,
  input  logic                  waitrequest,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic                auto_start_q;
  logic                pending_q;
  logic [CH_W-1:0]     ch_q;
  logic [1:0]          step_q;      // 0: HIGH_DUR, 1: TOTAL_DUR, 2: CONTROL
  logic [STALL_W-1:0]  stall_q;

  // Sweep snapshot
  logic [31:0]         period_s;
  logic [31:0]         duty_s [NUM_CH];
  logic [NUM_CH-1:0]   forward_s;
  logic [NUM_CH-1:0]   go_s;
  logic [NUM_CH-1:0]   fast_decay_s;

  logic                start;
  logic                timeout_hit;
  logic                last_write;
  logic                skip;
  logic [3:0]          reg_idx;
  logic [31:0]         duty_cur;
  logic [31:0]         cur_data;

  assign start       = auto_start_q | pending_q | update_req;
  assign timeout_hit = waitrequest && (stall_q == STALL_W'(TIMEOUT - 1));
  assign last_write  = (step_q == 2'd2) && (ch_q == CH_W'(NUM_CH - 1));

  // Register index and data for the current (channel, step)
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    duty_cur = duty_s[ch_q];
    reg_idx  = 4'd2;
    cur_data = {29'b0, fast_decay_s[ch_q], forward_s[ch_q], go_s[ch_q]};
    unique case (step_q)
      2'd0: begin
        reg_idx  = 4'd1;
        cur_data = (duty_cur < period_s) ? duty_cur : period_s;
      end
      2'd1: begin
        reg_idx  = 4'd0;
        cur_data = period_s;
      end
      default: ;
    endcase
  end

`ifdef SKIP_UNCHANGED_EN
  logic [31:0] shadow_q       [NUM_CH][3];
  logic [2:0]  shadow_valid_q [NUM_CH];

  assign skip = shadow_valid_q[ch_q][step_q] &&
                (shadow_q[ch_q][step_q] == cur_data);
`else
  assign skip = 1'b0;
`endif

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = skip ? S_GAP : S_WRITE;
      S_WRITE: begin
        if (!waitrequest)     state_d = S_GAP;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_GAP:   state_d = last_write ? S_DONE : S_LOAD;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register; all are low in IDLE, so the
  // asynchronous reset drops the strobes immediately.
  always_comb begin
    s_cs    = (state_q == S_WRITE);
    s_write = (state_q == S_WRITE);
    s_read  = 1'b0;
    busy    = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_GAP);
    done    = (state_q == S_DONE);
  end

  // Control and bus-register datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_start_q <= 1'b1;
      pending_q    <= 1'b0;
      err          <= 1'b0;
      ch_q         <= '0;
      step_q       <= '0;
      stall_q      <= '0;
      s_address    <= '0;
      s_writedata  <= '0;
`ifdef SKIP_UNCHANGED_EN
      for (int k = 0; k < NUM_CH; k++) shadow_valid_q[k] <= '0;
`endif
    end else begin
      // A request outside IDLE (including DONE) is remembered for one sweep.
      if (state_q != S_IDLE && update_req) pending_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            auto_start_q <= 1'b0;
            pending_q    <= 1'b0;
            err          <= 1'b0;
            ch_q         <= '0;
            step_q       <= '0;
          end
        end
        S_LOAD: begin
          s_address   <= {ch_q, reg_idx};
          s_writedata <= cur_data;
          stall_q     <= '0;
        end
        S_WRITE: begin
          if (!waitrequest) begin
`ifdef SKIP_UNCHANGED_EN
            shadow_valid_q[ch_q][step_q] <= 1'b1;
`endif
          end else if (timeout_hit) begin
            err <= 1'b1;
`ifdef SKIP_UNCHANGED_EN
            for (int k = 0; k < NUM_CH; k++) shadow_valid_q[k] <= '0;
`endif
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        S_GAP: begin
          if (step_q == 2'd2) begin
            step_q <= '0;
            ch_q   <= ch_q + 1'b1;
          end else begin
            step_q <= step_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Snapshot and shadow data carry no reset: they are only read after being
  // loaded (snapshot) or when their valid bit is set (shadow).
  // NOTE: storage whose contents are qualified elsewhere is left unreset,
  // which keeps reset fan-out off wide data registers.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      period_s     <= period;
      forward_s    <= forward;
      go_s         <= go;
      fast_decay_s <= fast_decay;
      for (int k = 0; k < NUM_CH; k++) duty_s[k] <= duty[32*k +: 32];
    end
`ifdef SKIP_UNCHANGED_EN
    if (state_q == S_WRITE && !waitrequest)
      shadow_q[ch_q][step_q] <= s_writedata;
`endif
  end

endmodule

// File: tb/tb_motor_cfg_master.sv
// -----------------------------------------------------------------------------
// tb_motor_cfg_master
//
// Scoreboard bench for motor_cfg_master (NUM_CH=2, CH_W=1, TIMEOUT=255).
// Expected writes are pushed when a sweep is requested; a bus monitor pops
// and compares them on every accepted write. Also checks reset state,
// request latency, waitrequest stability, timeout, request coalescing,
// period=0 and async reset mid-write. Build with +define+SKIP_UNCHANGED_EN
// to exercise the skip-unchanged model.
// -----------------------------------------------------------------------------
module tb_motor_cfg_master;

  localparam int NUM_CH  = 2;
  localparam int CH_W    = 1;
  localparam int TIMEOUT = 255;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [31:0]          period;
  logic [32*NUM_CH-1:0] duty;
  logic [NUM_CH-1:0]    forward, go, fast_decay;
  logic                 update_req;
  logic                 s_cs, s_write, s_read;
  logic [CH_W+3:0]      s_address;
  logic [31:0]          s_writedata;
  logic                 waitrequest;
  logic                 busy, done, err;

  always #5 clk = ~clk;

  motor_cfg_master #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .period     (period),
    .duty       (duty),
    .forward    (forward),
    .go         (go),
    .fast_decay (fast_decay),
    .update_req (update_req),
    .s_cs       (s_cs),
    .s_address  (s_address),
    .s_write    (s_write),
    .s_read     (s_read),
    .s_writedata(s_writedata),
    .waitrequest(waitrequest),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic [CH_W+3:0] addr;
    logic [31:0]     data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  done_cnt = 0;
  int  wr_cnt = 0;
  int  stall_cnt = 0;

`ifdef SKIP_UNCHANGED_EN
  logic [31:0] m_shadow [NUM_CH][3];
  logic        m_valid  [NUM_CH][3];
  initial for (int k = 0; k < NUM_CH; k++) for (int s = 0; s < 3; s++) m_valid[k][s] = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected writes of one sweep with the current inputs
  task automatic push_sweep();
    for (int k = 0; k < NUM_CH; k++) begin
      for (int s = 0; s < 3; s++) begin
        logic [31:0] dk, val;
        logic [3:0]  r;
        wr_t         e;
        dk = duty[32*k +: 32];
        case (s)
          0:       begin r = 4'h1; val = (dk < period) ? dk : period; end
          1:       begin r = 4'h0; val = period; end
          default: begin r = 4'h2; val = {29'b0, fast_decay[k], forward[k], go[k]}; end
        endcase
`ifdef SKIP_UNCHANGED_EN
        if (m_valid[k][s] && m_shadow[k][s] == val) continue;
        m_valid[k][s]  = 1'b1;
        m_shadow[k][s] = val;
`endif
        e.addr = {k[CH_W-1:0], r};
        e.data = val;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic model_invalidate();
`ifdef SKIP_UNCHANGED_EN
    for (int k = 0; k < NUM_CH; k++) for (int s = 0; s < 3; s++) m_valid[k][s] = 1'b0;
`endif
  endtask

  // One-cycle request pulse starting #1 after a rising edge
  task automatic req_pulse();
    @(posedge clk); #1;
    update_req = 1'b1;
    @(posedge clk); #1;
    update_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(tag, done_cnt, target);
  endtask

  task automatic wait_write(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_write && n < 20);
    check(tag, s_write, 1'b1);
  endtask

  // Bus monitor: samples on the falling edge
  initial begin
    logic            prev_stall = 1'b0;
    logic [CH_W+3:0] prev_addr;
    logic [31:0]     prev_data;
    wr_t             e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (s_write) begin
          if (s_cs !== 1'b1 || s_read !== 1'b0) check("cs_read", {s_cs, s_read}, 2'b10);
          if (prev_stall) begin
            check("stall_addr_stable", s_address, prev_addr);
            check("stall_data_stable", s_writedata, prev_data);
          end
          if (waitrequest) begin
            stall_cnt++;
            prev_stall = 1'b1;
            prev_addr  = s_address;
            prev_data  = s_writedata;
          end else begin
            wr_cnt++;
            prev_stall = 1'b0;
            if (exp_q.size() == 0) begin
              check("write_expected", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              check("wr_addr", s_address, e.addr);
              check("wr_data", s_writedata, e.data);
            end
          end
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, first_wr, base, wr_before;

    reset_n     = 1'b1;
    period      = 32'd7000;
    duty        = {32'd2000, 32'd3500};
    forward     = 2'b11;
    go          = 2'b11;
    fast_decay  = 2'b00;
    update_req  = 1'b0;
    waitrequest = 1'b0;
    #2 reset_n  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {s_cs, s_write, s_read, busy, done, err}, 6'b0);
    check("rst_addr", s_address, 0);
    check("rst_data", s_writedata, 0);

    // Automatic sweep after reset release: done in the 20th cycle
    push_sweep();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) check("auto_busy", busy, 1'b1);
    end while (!done && cyc < 100);
    check("auto_done_cycle", cyc, 20);
    check("auto_err", err, 1'b0);
    @(posedge clk);
    check("auto_q_empty", exp_q.size(), 0);

    // duty1 above period is clamped; request latency
    @(posedge clk); #1;
    duty[63:32] = 32'd9000;
    push_sweep();
    update_req = 1'b1;
    fork begin @(posedge clk); #1 update_req = 1'b0; end join_none
    cyc = 0;
    first_wr = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (s_write && first_wr == 0) first_wr = cyc;
    end while (!done && cyc < 100);
    check("req_first_write_cycle", first_wr, 3);
    check("req_done_cycle", cyc, 20);
    @(posedge clk);
    check("clamp_q_empty", exp_q.size(), 0);

    // Four stalled cycles on the first write
    @(posedge clk); #1;
    period = 32'd6000;
    push_sweep();
    stall_cnt   = 0;
    waitrequest = 1'b1;
    base = done_cnt;
    req_pulse();
    wait_write("stall_write_seen");
    repeat (4) @(posedge clk);
    #1 waitrequest = 1'b0;
    wait_done("stall_done", base + 1, 100);
    check("stall_cycles", stall_cnt, 4);
    check("stall_err", err, 1'b0);
    check("stall_q_empty", exp_q.size(), 0);

    // Timeout: waitrequest held for 300 cycles
    @(posedge clk); #1;
    period      = 32'd5000;
    stall_cnt   = 0;
    wr_before   = wr_cnt;
    waitrequest = 1'b1;
    base = done_cnt;
    req_pulse();
    wait_done("timeout_done", base + 1, 400);
    @(negedge clk);
    check("timeout_stalls", stall_cnt, TIMEOUT);
    check("timeout_err", err, 1'b1);
    check("timeout_idle", {busy, s_write, s_cs}, 3'b000);
    repeat (30) @(posedge clk);
    #1 waitrequest = 1'b0;
    @(negedge clk);
    check("timeout_no_write", wr_cnt, wr_before);
    check("timeout_err_sticky", err, 1'b1);
    model_invalidate();

    // Next request clears err and runs a full sweep
    push_sweep();
    base = done_cnt;
    req_pulse();
    @(negedge clk);
    check("err_cleared", err, 1'b0);
    wait_done("recover_done", base + 1, 100);
    check("recover_q_empty", exp_q.size(), 0);

    // Three requests mid-sweep coalesce into one sweep with a fresh snapshot
    @(posedge clk); #1;
    period = 32'd4000;
    duty[31:0] = 32'd1000;
    push_sweep();
    base = done_cnt;
    req_pulse();
    repeat (3) @(posedge clk);
    #1;
    period     = 32'd0;
    forward    = 2'b01;
    fast_decay = 2'b10;
    go         = 2'b01;
    push_sweep();
    repeat (3) begin
      req_pulse();
      repeat (2) @(posedge clk);
    end
    wait_done("coalesce_done", base + 2, 200);
    repeat (40) @(posedge clk);
    check("coalesce_single_extra", done_cnt, base + 2);
    check("coalesce_q_empty", exp_q.size(), 0);

    // Request with unchanged inputs (skipped entirely when skip is built in)
    wr_before = wr_cnt;
    push_sweep();
    base = done_cnt;
    req_pulse();
    wait_done("same_done", base + 1, 100);
    check("same_writes", wr_cnt - wr_before, 6 - 6 * int'(exp_q.size() == 0 && wr_cnt == wr_before));
    check("same_q_empty", exp_q.size(), 0);

    // Asynchronous reset during a stalled write
    @(posedge clk); #1;
    period      = 32'd1234;
    waitrequest = 1'b1;
    req_pulse();
    wait_write("arst_write_seen");
    #2 reset_n = 1'b0;
    #1;
    check("arst_strobes", {s_write, s_cs, busy}, 3'b000);
    model_invalidate();
    push_sweep();
    waitrequest = 1'b0;
    base = done_cnt;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_done("arst_auto_done", base + 1, 100);
    check("arst_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
